// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program counter / fetch sequencer that drives the instruction ROM address.
// When Start is pulsed, the PC is loaded with StartAddr and the unit enters RUN.
// In RUN it advances the PC once per cycle in one of these ways:
//   - sequential increment,
//   - relative branch,
//   - absolute jump,
//   - call/return (optional).
// It stops on Halt and then reports Done.
//
// Optional feature: define FETCH_RAS_EN to add a RAS_DEPTH-entry
// return-address stack for Call/Ret. Without it, Call/Ret are ignored and
// RasErr is tied low. The port list is the same in both builds.
//
// Ports
//   CLK          in   1     clock, rising edge
//   Reset        in   1     synchronous active-high reset
//   Start        in   1     load StartAddr, clear counters/flags, enter RUN
//   StartAddr    in   AW    program entry address
//   Stall        in   1     hold PC/count/state this cycle
//   Halt         in   1     halt instruction; go to HALTED (counts as retired)
//   BranchTaken  in   1     relative branch: PC <= PC + BranchOffset
//   BranchOffset in   AW    signed two's-complement offset
//   JumpEn       in   1     absolute jump: PC <= JumpTarget
//   JumpTarget   in   AW    jump / call target
//   Call         in   1     push PC+1, PC <= JumpTarget (stack build only)
//   Ret          in   1     pop return address into PC (stack build only)
//   InstrAddress out  AW    current PC (registered)
//   Running      out  1     registered: state is RUN
//   Done         out  1     registered: state is HALTED
//   InstrCount   out  CNTW  retired instructions since Start, saturating
//   RasErr       out  1     sticky stack overflow/underflow flag
//
// Next-PC priority in RUN: Stall > Halt > Ret > Call > JumpEn > BranchTaken > PC+1.
// Start overrides everything in any state; Reset overrides Start.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int AW        = 8,
  parameter int CNTW      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [AW-1:0]   StartAddr,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            BranchTaken,
  input  logic [AW-1:0]   BranchOffset,
  input  logic            JumpEn,
  input  logic [AW-1:0]   JumpTarget,
  input  logic            Call,
  input  logic            Ret,
  output logic [AW-1:0]   InstrAddress,
  output logic            Running,
  output logic            Done,
  output logic [CNTW-1:0] InstrCount,
  output logic            RasErr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            running_q, done_q;
  logic [AW-1:0]   pc_inc;

  assign pc_inc = pc_q + AW'(1);

`ifdef FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH + 1);  // pointer: 0..RAS_DEPTH entries
  localparam int IW = $clog2(RAS_DEPTH);      // entry index

  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d;
  logic          ras_err_q, ras_err_d;
  logic          push_en;
  logic [IW-1:0] push_idx, top_idx;

  // ras_ptr_q counts valid entries; the top of the stack is entry ras_ptr_q-1.
  assign push_idx = IW'(ras_ptr_q);
  assign top_idx  = IW'(ras_ptr_q - PW'(1));
`endif

  // Next-state / next-PC logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef FETCH_RAS_EN
    ras_ptr_d = ras_ptr_q;
    ras_err_d = ras_err_q;
    push_en   = 1'b0;
`endif
    if (Start) begin
      state_d = ST_RUN;
      pc_d    = StartAddr;
      cnt_d   = '0;
`ifdef FETCH_RAS_EN
      ras_ptr_d = '0;
      ras_err_d = 1'b0;
`endif
    end else if (state_q == ST_RUN && !Stall) begin
      // Every non-stalled RUN cycle retires one instruction, halt included.
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
      if (Halt) begin
        state_d = ST_HALTED;
      end
`ifdef FETCH_RAS_EN
      else if (Ret) begin
        if (ras_ptr_q == '0) begin
          // Underflow: fall through sequentially and flag it.
          pc_d      = pc_inc;
          ras_err_d = 1'b1;
        end else begin
          pc_d      = ras_q[top_idx];
          ras_ptr_d = ras_ptr_q - PW'(1);
        end
      end else if (Call) begin
        pc_d = JumpTarget;
        if (ras_ptr_q == PW'(RAS_DEPTH)) begin
          // Overflow: still take the call, but the return address is lost.
          ras_err_d = 1'b1;
        end else begin
          push_en   = 1'b1;
          ras_ptr_d = ras_ptr_q + PW'(1);
        end
      end
`endif
      else if (JumpEn) begin
        pc_d = JumpTarget;
      end else if (BranchTaken) begin
        pc_d = pc_q + BranchOffset;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // State register. Running/Done are registered decodes of the next state, so
  // they track state_q exactly with no combinational path from the inputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_HALTED);
    end
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ras_ptr_q <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_err_q <= ras_err_d;
    end
  end

  // Stack storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge CLK) begin
    if (push_en) ras_q[push_idx] <= pc_inc;
  end

  assign RasErr = ras_err_q;
`else
  logic unused_ras_inputs;
  localparam int unused_ras_depth = RAS_DEPTH;
  assign unused_ras_inputs = Call ^ Ret;
  assign RasErr = 1'b0;
`endif

  assign InstrAddress = pc_q;
  assign Running      = running_q;
  assign Done         = done_q;
  assign InstrCount   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The counter is built 4 bits wide so that
// saturation can be reached in a few cycles. Expected PCs are queued when a
// step is driven and popped after the clock edge. Other outputs are compared
// against constants worked out by hand from the behaviour description.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW   = 8;
  localparam int CNTW = 4;

  logic            CLK;
  logic            Reset;
  logic            Start;
  logic [AW-1:0]   StartAddr;
  logic            Stall;
  logic            Halt;
  logic            BranchTaken;
  logic [AW-1:0]   BranchOffset;
  logic            JumpEn;
  logic [AW-1:0]   JumpTarget;
  logic            Call;
  logic            Ret;
  logic [AW-1:0]   InstrAddress;
  logic            Running;
  logic            Done;
  logic [CNTW-1:0] InstrCount;
  logic            RasErr;

  logic [AW-1:0] exp_q[$];
  int            vectors;
  int            miscompares;

  fetch_unit #(.AW(AW), .CNTW(CNTW), .RAS_DEPTH(4)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Stall        (Stall),
    .Halt         (Halt),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .JumpEn       (JumpEn),
    .JumpTarget   (JumpTarget),
    .Call         (Call),
    .Ret          (Ret),
    .InstrAddress (InstrAddress),
    .Running      (Running),
    .Done         (Done),
    .InstrCount   (InstrCount),
    .RasErr       (RasErr)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic clear_inputs();
    Start        = 1'b0;
    StartAddr    = '0;
    Stall        = 1'b0;
    Halt         = 1'b0;
    BranchTaken  = 1'b0;
    BranchOffset = '0;
    JumpEn       = 1'b0;
    JumpTarget   = '0;
    Call         = 1'b0;
    Ret          = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge, and outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: queue the expected PC, clock, then pop and compare.
  task automatic step_pc(input string tag, input logic [AW-1:0] exp_pc);
    logic [AW-1:0] e;
    exp_q.push_back(exp_pc);
    tick();
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(InstrAddress), 32'(e));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_inputs();
    Reset = 1'b1;

    // Reset state
    step_pc("reset_pc", 8'h00);
    chk("reset_running", 32'(Running), 0);
    chk("reset_done", 32'(Done), 0);
    chk("reset_count", 32'(InstrCount), 0);
    chk("reset_raserr", 32'(RasErr), 0);
    Reset = 1'b0;

    // IDLE ignores control inputs other than Start
    JumpEn = 1'b1; JumpTarget = 8'h55; Halt = 1'b1;
    step_pc("idle_ignore_pc", 8'h00);
    chk("idle_running", 32'(Running), 0);
    clear_inputs();

    // Run to PC 0x37, then reset mid-run
    Start = 1'b1; StartAddr = 8'h30;
    step_pc("start30_pc", 8'h30);
    Start = 1'b0;
    chk("start30_running", 32'(Running), 1);
    for (int i = 1; i <= 7; i++) step_pc("seq30_pc", 8'(8'h30 + i));
    chk("seq30_count", 32'(InstrCount), 7);
    Reset = 1'b1;
    step_pc("midreset_pc", 8'h00);
    chk("midreset_running", 32'(Running), 0);
    chk("midreset_done", 32'(Done), 0);
    chk("midreset_count", 32'(InstrCount), 0);
    Reset = 1'b0;

    // Start at 0xFE, wrap through 0xFF -> 0x00
    Start = 1'b1; StartAddr = 8'hFE;
    step_pc("startfe_pc", 8'hFE);
    Start = 1'b0;
    step_pc("wrap_pc1", 8'hFF);
    step_pc("wrap_pc2", 8'h00);
    step_pc("wrap_pc3", 8'h01);
    chk("wrap_count", 32'(InstrCount), 3);

    // Jump, negative branch, jump beats branch, positive branch
    JumpEn = 1'b1; JumpTarget = 8'h10;
    step_pc("jump10_pc", 8'h10);
    JumpEn = 1'b0;
    BranchTaken = 1'b1; BranchOffset = 8'hF8;
    step_pc("branch_neg_pc", 8'h08);
    JumpEn = 1'b1; JumpTarget = 8'h40; BranchOffset = 8'h05;
    step_pc("jump_over_branch_pc", 8'h40);
    JumpEn = 1'b0; BranchOffset = 8'h10;
    step_pc("branch_pos_pc", 8'h50);
    BranchTaken = 1'b0;
    chk("branch_count", 32'(InstrCount), 7);

    // Stall holds over Halt; Halt alone then retires one instruction
    JumpEn = 1'b1; JumpTarget = 8'h20;
    step_pc("jump20_pc", 8'h20);
    JumpEn = 1'b0;
    Stall = 1'b1; Halt = 1'b1; JumpEn = 1'b1; JumpTarget = 8'h99;
    step_pc("stall1_pc", 8'h20);
    step_pc("stall2_pc", 8'h20);
    chk("stall_count", 32'(InstrCount), 8);
    chk("stall_done", 32'(Done), 0);
    chk("stall_running", 32'(Running), 1);
    Stall = 1'b0; JumpEn = 1'b0;
    step_pc("halt_pc", 8'h20);
    Halt = 1'b0;
    chk("halt_done", 32'(Done), 1);
    chk("halt_running", 32'(Running), 0);
    chk("halt_count", 32'(InstrCount), 9);

    // HALTED ignores control inputs; Done is sticky
    BranchTaken = 1'b1; BranchOffset = 8'h04;
    step_pc("halted_ignore_pc", 8'h20);
    chk("halted_done_sticky", 32'(Done), 1);
    BranchTaken = 1'b0;

    // Start from HALTED wins over a simultaneous Halt/Jump
    Start = 1'b1; StartAddr = 8'h05; Halt = 1'b1; JumpEn = 1'b1; JumpTarget = 8'hAA;
    step_pc("restart_pc", 8'h05);
    clear_inputs();
    chk("restart_done", 32'(Done), 0);
    chk("restart_running", 32'(Running), 1);
    chk("restart_count", 32'(InstrCount), 0);

`ifdef FETCH_RAS_EN
    // Return-address stack: fill, overflow, drain, underflow
    JumpEn = 1'b1; JumpTarget = 8'h10;
    step_pc("ras_jump10_pc", 8'h10);
    JumpEn = 1'b0;
    Call = 1'b1; JumpTarget = 8'h80;
    for (int i = 0; i < 4; i++) step_pc("ras_call_pc", 8'h80);
    chk("ras_full_noerr", 32'(RasErr), 0);
    step_pc("ras_call5_pc", 8'h80);
    chk("ras_overflow_err", 32'(RasErr), 1);
    Call = 1'b0; Ret = 1'b1;
    step_pc("ras_ret1_pc", 8'h81);
    step_pc("ras_ret2_pc", 8'h81);
    step_pc("ras_ret3_pc", 8'h81);
    step_pc("ras_ret4_pc", 8'h11);
    step_pc("ras_underflow_pc", 8'h12);
    chk("ras_underflow_err", 32'(RasErr), 1);
    Ret = 1'b0;
    // Start clears RasErr; Ret beats Call in the same cycle
    Start = 1'b1; StartAddr = 8'h60;
    step_pc("ras_start60_pc", 8'h60);
    Start = 1'b0;
    chk("ras_start_clears_err", 32'(RasErr), 0);
    Call = 1'b1; JumpTarget = 8'h80;
    step_pc("ras_call60_pc", 8'h80);
    Ret = 1'b1; JumpTarget = 8'h90;
    step_pc("ras_ret_wins_pc", 8'h61);
    chk("ras_ret_wins_err", 32'(RasErr), 0);
    Call = 1'b0;
    step_pc("ras_empty_again_pc", 8'h62);
    chk("ras_empty_again_err", 32'(RasErr), 1);
    Ret = 1'b0;
`else
    // Without the stack, Call/Ret fall through as sequential fetches
    Call = 1'b1; JumpTarget = 8'h80;
    step_pc("noras_call_pc", 8'h06);
    Call = 1'b0; Ret = 1'b1;
    step_pc("noras_ret_pc", 8'h07);
    Ret = 1'b0;
    chk("noras_raserr", 32'(RasErr), 0);
`endif

    // Counter saturation (4-bit counter tops out at 15)
    Start = 1'b1; StartAddr = 8'h00;
    step_pc("sat_start_pc", 8'h00);
    Start = 1'b0;
    for (int i = 1; i <= 14; i++) step_pc("sat_seq_pc", 8'(i));
    chk("sat_count_14", 32'(InstrCount), 14);
    for (int i = 15; i <= 20; i++) step_pc("sat_seq_pc", 8'(i));
    chk("sat_count_held", 32'(InstrCount), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
